// File: rtl/pll_reset_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_reset_pkg;

   // Sequencer states; RUN is the only state in which downstream logic is released.
   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABILIZE = 2'd1,
      HOLD_RST  = 2'd2,
      RUN       = 2'd3
   } state_t;

   // Larger of two integers, used to size the shared qualification/hold counter.
   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pll_reset_seq_bit_sync.sv
// Two-flop synchronizer for a single asynchronous level, cleared by a synchronous reset.
module bit_sync (
   input  logic clk,
   input  logic srst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // First flop may go metastable; second flop gives it a full cycle to settle.
   always_ff @(posedge clk) begin
      if (srst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_seq.sv
// Qualifies PLL lock before releasing sys_rst, turns the 10 kHz PLL output into
// a one-cycle tick enable, and counts lock losses seen while running.
module pll_reset_seq
   import pll_reset_pkg::*;
#(
   parameter int LOCK_CYCLES = 4800,
   parameter int HOLD_CYCLES = 48,
   parameter int LOSS_W      = 8
) (
   input  logic              lcd_clk,
   input  logic              rst,
   input  logic              locked,
   input  logic              clk_10kHz,
   output logic              sys_rst,
   output logic              ready,
   output logic              tick_10k,
   output logic [LOSS_W-1:0] loss_cnt
);

   localparam int CNT_W = $clog2(max2(LOCK_CYCLES, HOLD_CYCLES) + 1);
   localparam logic [CNT_W-1:0]  LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
   localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [LOSS_W-1:0] LOSS_MAX  = {LOSS_W{1'b1}};

   logic [1:0]        w_async_in;
   logic [1:0]        w_sync_out;
   logic              w_lk;
   logic              w_c2;

   state_t            r_state;
   state_t            w_state_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_next;
   logic [LOSS_W-1:0] r_loss;
   logic [LOSS_W-1:0] w_loss_next;
   logic              r_c3;
   logic              r_sys_rst;
   logic              r_ready;
   logic              r_tick;

   // Bit 0 carries PLL lock, bit 1 the 10 kHz clock sampled as data.
   assign w_async_in = {clk_10kHz, locked};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_sync
         bit_sync u_sync (
            .clk  (lcd_clk),
            .srst (rst),
            .i_d  (w_async_in[gi]),
            .o_q  (w_sync_out[gi])
         );
      end
   endgenerate

   assign w_lk = w_sync_out[0];
   assign w_c2 = w_sync_out[1];

   // Next-state, counter and loss-counter decode; any drop of lk falls back to WAIT_LOCK.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_loss_next  = r_loss;
      case (r_state)
         WAIT_LOCK: begin
            if (w_lk) begin
               w_state_next = STABILIZE;
               w_cnt_next   = '0;
            end
         end
         STABILIZE: begin
            if (!w_lk) begin
               w_state_next = WAIT_LOCK;
            end else if (r_cnt == LOCK_LAST) begin
               w_state_next = HOLD_RST;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         HOLD_RST: begin
            if (!w_lk) begin
               w_state_next = WAIT_LOCK;
            end else if (r_cnt == HOLD_LAST) begin
               w_state_next = RUN;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         RUN: begin
            if (!w_lk) begin
               w_state_next = WAIT_LOCK;
               // Only losses out of RUN count; the counter sticks at all-ones.
               if (r_loss != LOSS_MAX) begin
                  w_loss_next = r_loss + 1'b1;
               end
            end
         end
         default: begin
            w_state_next = WAIT_LOCK;
         end
      endcase
   end

   // State, counters and output registers; sys_rst/ready are loaded from the same
   // next-state as r_state, so they always equal a decode of the state register.
   always_ff @(posedge lcd_clk) begin
      if (rst) begin
         r_state   <= WAIT_LOCK;
         r_cnt     <= '0;
         r_loss    <= '0;
         r_c3      <= 1'b0;
         r_sys_rst <= 1'b1;
         r_ready   <= 1'b0;
         r_tick    <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_cnt     <= w_cnt_next;
         r_loss    <= w_loss_next;
         r_c3      <= w_c2;
         r_sys_rst <= (w_state_next != RUN);
         r_ready   <= (w_state_next == RUN);
         // Rising edge of the synchronized 10 kHz clock, suppressed when leaving RUN.
         r_tick    <= w_c2 & ~r_c3 & (w_state_next == RUN);
      end
   end

   assign sys_rst  = r_sys_rst;
   assign ready    = r_ready;
   assign tick_10k = r_tick;
   assign loss_cnt = r_loss;

endmodule
